// File: rtl/kc705_ethernet_axi_rx_frame_parser_pkg.sv
// Shared types and constants for the KC705 Ethernet RX command-frame parser.
package kc705_eth_rx_pkg;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    HEADER,
    SIZE,
    COUNTER,
    DATA,
    DRAIN
  } state_t;

  localparam int HDR_LEN_NOVLAN = 14;
  localparam int HDR_LEN_VLAN   = 18;

  localparam logic [47:0] BCAST_MAC = 48'hffff_ffff_ffff;

endpackage

// File: rtl/kc705_ethernet_axi_rx_frame_parser_if.sv
// RX byte stream (from TEMAC) and packed payload stream (to command FIFO).
// slave = the parser; master = the TEMAC / FIFO side that drives it.
interface kc705_ethernet_axi_rx_frame_parser_if #(
  parameter int OUT_BYTES = 4
);
  logic [7:0]             rx_axis_tdata;
  logic                   rx_axis_tvalid;
  logic                   rx_axis_tlast;
  logic                   rx_axis_tready;
  logic [8*OUT_BYTES-1:0] m_axis_tdata;
  logic [OUT_BYTES-1:0]   m_axis_tkeep;
  logic                   m_axis_tvalid;
  logic                   m_axis_tlast;
  logic                   m_axis_tready;

  modport slave (
    input  rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, m_axis_tready,
    output rx_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, m_axis_tready,
    input  rx_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/kc705_ethernet_axi_rx_frame_parser_byte_packer.sv
// Packs payload bytes into OUT_BYTES-wide words behind a single output register.
module kc705_eth_rx_byte_packer #(
  parameter int OUT_BYTES = 4
) (
  input  logic                   axi_tclk,
  input  logic                   axi_treset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]   out_keep,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready
);
  localparam int FW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  logic [FW-1:0]          fill;
  logic [8*OUT_BYTES-1:0] acc;
  logic [8*OUT_BYTES-1:0] word;
  logic [OUT_BYTES-1:0]   keep;
  logic                   full;

  assign in_ready = !out_valid || out_ready;
  assign full     = (fill == FW'(OUT_BYTES - 1));

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    word = acc;
    word[8*fill +: 8] = in_data;
    keep = '0;
    for (int i = 0; i < OUT_BYTES; i++) keep[i] = (i <= int'(fill));
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge axi_tclk or posedge axi_treset) begin
    if (axi_treset) begin
      fill      <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (in_valid) begin
        if (full || in_last) begin
          out_data  <= word;
          out_keep  <= keep;
          out_last  <= in_last;
          out_valid <= 1'b1;
          acc       <= '0;
          fill      <= '0;
        end else begin
          acc  <= word;
          fill <= fill + FW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/kc705_ethernet_axi_rx_frame_parser.sv
// Ethernet command-frame parser: header/size/counter fields, packed payload, metadata, stats.
// Optional destination-address filter enabled by defining RX_ADDR_FILTER_EN.
module kc705_ethernet_axi_rx_frame_parser
  import kc705_eth_rx_pkg::*;
#(
  parameter logic [47:0] DEST_ADDR    = 48'hda0102030405,
  parameter logic [15:0] MAX_SIZE     = 16'd1500,
  parameter bit          ENABLE_VLAN  = 1'b0,
  parameter int          PKT_SIZE_LEN = 2,
  parameter int          PKT_CTR_LEN  = 2,
  parameter int          OUT_BYTES    = 4
) (
  input  logic                      axi_tclk,
  input  logic                      axi_treset,
  input  logic                      enable_rx_decode,
  kc705_ethernet_axi_rx_frame_parser_if.slave axis,
  output logic                      meta_valid,
  output logic [8*PKT_SIZE_LEN-1:0] meta_pkt_size,
  output logic [8*PKT_CTR_LEN-1:0]  meta_pkt_counter,
  output logic [47:0]               meta_src_mac,
  output logic                      seq_err,
  output logic                      frame_err,
  output logic [31:0]               stat_frames_ok,
  output logic [31:0]               stat_frames_dropped
);
  localparam int SW = 8 * PKT_SIZE_LEN;
  localparam int CW = 8 * PKT_CTR_LEN;
  localparam logic [7:0] HDR_LEN = ENABLE_VLAN ? 8'(HDR_LEN_VLAN) : 8'(HDR_LEN_NOVLAN);
`ifdef RX_ADDR_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  state_t        state;
  logic          running;
  logic [7:0]    byte_cnt;
  logic [47:0]   dst_mac, src_mac, dst_next, src_next;
  logic [SW-1:0] pkt_size, size_next, data_cnt;
  logic [CW-1:0] ctr_shift, ctr_next, seq_ref;
  logic          seq_ref_valid;
  logic          packer_ready, xfer, data_xfer, last_payload, pack_last, dst_ok;

  // tready stays low through reset and the first cycle after it.
  assign axis.rx_axis_tready = running && (state != DATA || packer_ready);
  assign xfer         = axis.rx_axis_tvalid && axis.rx_axis_tready;
  assign data_xfer    = xfer && (state == DATA);
  assign last_payload = (data_cnt == pkt_size - SW'(1));
  assign pack_last    = last_payload || axis.rx_axis_tlast;
  assign dst_next     = {dst_mac[39:0], axis.rx_axis_tdata};
  assign src_next     = {src_mac[39:0], axis.rx_axis_tdata};
  assign size_next    = SW'({pkt_size, axis.rx_axis_tdata});
  assign ctr_next     = CW'({ctr_shift, axis.rx_axis_tdata});
  assign dst_ok       = (dst_next == DEST_ADDR) || (dst_next == BCAST_MAC);

  always_ff @(posedge axi_tclk or posedge axi_treset) begin
    if (axi_treset) begin
      state               <= SYNC;
      running             <= 1'b0;
      byte_cnt            <= '0;
      dst_mac             <= '0;
      src_mac             <= '0;
      pkt_size            <= '0;
      ctr_shift           <= '0;
      data_cnt            <= '0;
      seq_ref             <= '0;
      seq_ref_valid       <= 1'b0;
      meta_valid          <= 1'b0;
      meta_pkt_size       <= '0;
      meta_pkt_counter    <= '0;
      meta_src_mac        <= '0;
      seq_err             <= 1'b0;
      frame_err           <= 1'b0;
      stat_frames_ok      <= '0;
      stat_frames_dropped <= '0;
    end else begin
      running    <= 1'b1;
      meta_valid <= 1'b0;
      seq_err    <= 1'b0;
      frame_err  <= 1'b0;
      // A frame ending anywhere before the payload is a runt.
      if (xfer && axis.rx_axis_tlast &&
          ((state inside {HEADER, SIZE, COUNTER}) || (state == IDLE && enable_rx_decode))) begin
        stat_frames_dropped <= stat_frames_dropped + 32'd1;
        frame_err           <= 1'b1;
        state               <= IDLE;
      end else begin
        case (state)
          SYNC: if (!axis.rx_axis_tvalid || (xfer && axis.rx_axis_tlast)) state <= IDLE;
          IDLE: if (xfer) begin
            if (!enable_rx_decode) begin
              if (!axis.rx_axis_tlast) state <= DRAIN;
            end else begin
              dst_mac  <= dst_next;
              byte_cnt <= 8'd1;
              state    <= HEADER;
            end
          end
          HEADER: if (xfer) begin
            if (byte_cnt < 8'd6) dst_mac <= dst_next;
            else if (byte_cnt < 8'd12) src_mac <= src_next;
            byte_cnt <= byte_cnt + 8'd1;
            if (FILTER_EN && byte_cnt == 8'd5 && !dst_ok) begin
              stat_frames_dropped <= stat_frames_dropped + 32'd1;
              state               <= DRAIN;
            end else if (byte_cnt == HDR_LEN - 8'd1) begin
              byte_cnt <= '0;
              state    <= SIZE;
            end
          end
          SIZE: if (xfer) begin
            pkt_size <= size_next;
            byte_cnt <= byte_cnt + 8'd1;
            if (byte_cnt == 8'(PKT_SIZE_LEN - 1)) begin
              byte_cnt <= '0;
              state    <= COUNTER;
            end
          end
          COUNTER: if (xfer) begin
            ctr_shift <= ctr_next;
            byte_cnt  <= byte_cnt + 8'd1;
            if (byte_cnt == 8'(PKT_CTR_LEN - 1)) begin
              byte_cnt         <= '0;
              data_cnt         <= '0;
              meta_valid       <= 1'b1;
              meta_pkt_size    <= pkt_size;
              meta_pkt_counter <= ctr_next;
              meta_src_mac     <= src_mac;
              seq_err          <= seq_ref_valid && (ctr_next != seq_ref + CW'(1));
              seq_ref          <= ctr_next;
              seq_ref_valid    <= 1'b1;
              if (64'(pkt_size) > 64'(MAX_SIZE)) begin
                stat_frames_dropped <= stat_frames_dropped + 32'd1;
                state               <= DRAIN;
              end else if (pkt_size == '0) begin
                stat_frames_ok <= stat_frames_ok + 32'd1;
                state          <= DRAIN;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: if (data_xfer) begin
            data_cnt <= data_cnt + SW'(1);
            if (last_payload) begin
              stat_frames_ok <= stat_frames_ok + 32'd1;
              state          <= axis.rx_axis_tlast ? IDLE : DRAIN;
            end else if (axis.rx_axis_tlast) begin
              stat_frames_dropped <= stat_frames_dropped + 32'd1;
              frame_err           <= 1'b1;
              state               <= IDLE;
            end
          end
          DRAIN: if (xfer && axis.rx_axis_tlast) state <= IDLE;
          default: state <= SYNC;
        endcase
      end
    end
  end

  kc705_eth_rx_byte_packer #(.OUT_BYTES(OUT_BYTES)) u_packer (
    .axi_tclk  (axi_tclk),
    .axi_treset(axi_treset),
    .in_valid  (data_xfer),
    .in_data   (axis.rx_axis_tdata),
    .in_last   (pack_last),
    .in_ready  (packer_ready),
    .out_data  (axis.m_axis_tdata),
    .out_keep  (axis.m_axis_tkeep),
    .out_valid (axis.m_axis_tvalid),
    .out_last  (axis.m_axis_tlast),
    .out_ready (axis.m_axis_tready)
  );
endmodule

// File: tb/tb_kc705_ethernet_axi_rx_frame_parser.sv
// Randomized scoreboard bench for kc705_ethernet_axi_rx_frame_parser (default parameters).
module tb_kc705_ethernet_axi_rx_frame_parser;
  localparam int          OB   = 4;
  localparam int          HDR  = 14;
  localparam logic [47:0] DEST = 48'hda0102030405;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } word_t;
  typedef struct { logic [15:0] size; logic [15:0] ctr; logic [47:0] src; logic seq; } meta_t;

  logic        axi_tclk = 1'b0;
  logic        axi_treset = 1'b1;
  logic        enable_rx_decode = 1'b0;
  logic        meta_valid, seq_err, frame_err;
  logic [15:0] meta_pkt_size, meta_pkt_counter;
  logic [47:0] meta_src_mac;
  logic [31:0] stat_frames_ok, stat_frames_dropped;

  kc705_ethernet_axi_rx_frame_parser_if #(.OUT_BYTES(OB)) axis ();

  kc705_ethernet_axi_rx_frame_parser #(.OUT_BYTES(OB)) dut (
    .axi_tclk           (axi_tclk),
    .axi_treset         (axi_treset),
    .enable_rx_decode   (enable_rx_decode),
    .axis               (axis),
    .meta_valid         (meta_valid),
    .meta_pkt_size      (meta_pkt_size),
    .meta_pkt_counter   (meta_pkt_counter),
    .meta_src_mac       (meta_src_mac),
    .seq_err            (seq_err),
    .frame_err          (frame_err),
    .stat_frames_ok     (stat_frames_ok),
    .stat_frames_dropped(stat_frames_dropped)
  );

  always #5 axi_tclk = ~axi_tclk;

  word_t       exp_words[$];
  meta_t       exp_meta[$];
  int          checks = 0, failures = 0;
  int          exp_ok = 0, exp_dropped = 0, exp_ferr = 0, seen_ferr = 0;
  bit          ref_valid = 1'b0;
  logic [15:0] ref_ctr = '0;
  int          gap_pct = 0;
  bit          stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bq_t make_frame(input logic [47:0] dst, input logic [47:0] src,
                                     input logic [15:0] size, input logic [15:0] ctr,
                                     input int npay, input int npad, input bit seq_pay,
                                     input int trunc);
    bq_t q;
    for (int i = 5; i >= 0; i--) q.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) q.push_back(src[8*i +: 8]);
    q.push_back(8'h88); q.push_back(8'hb5);
    q.push_back(size[15:8]); q.push_back(size[7:0]);
    q.push_back(ctr[15:8]);  q.push_back(ctr[7:0]);
    for (int i = 0; i < npay; i++) q.push_back(seq_pay ? 8'(i + 1) : 8'($urandom));
    for (int i = 0; i < npad; i++) q.push_back(8'($urandom));
    if (trunc > 0) while (q.size() > trunc) void'(q.pop_back());
    return q;
  endfunction

  // Reference model: derives the expected outputs of a whole frame from its bytes.
  task automatic model_frame(input bq_t fr, input bit en);
    int          n = fr.size();
    logic [47:0] dst = '0, src = '0;
    logic [15:0] size, ctr, nxt;
    meta_t       m;
    int          avail, take, cnt;
    word_t       w;
    if (!en) return;
    if (n >= 6) for (int i = 0; i < 6; i++) dst = {dst[39:0], fr[i]};
`ifdef RX_ADDR_FILTER_EN
    if (n > 6 && dst != DEST && dst != 48'hffffffffffff) begin exp_dropped++; return; end
`endif
    if (n <= HDR + 4) begin exp_dropped++; exp_ferr++; return; end
    for (int i = 6; i < 12; i++) src = {src[39:0], fr[i]};
    size = {fr[HDR], fr[HDR+1]};
    ctr  = {fr[HDR+2], fr[HDR+3]};
    nxt  = ref_ctr + 16'd1;
    m.size = size; m.ctr = ctr; m.src = src; m.seq = ref_valid && (ctr != nxt);
    exp_meta.push_back(m);
    ref_valid = 1'b1;
    ref_ctr = ctr;
    if (size > 16'd1500) begin exp_dropped++; return; end
    if (size == 0) begin exp_ok++; return; end
    avail = n - HDR - 4;
    take  = (avail < int'(size)) ? avail : int'(size);
    for (int i = 0; i < take; i += OB) begin
      cnt = (take - i < OB) ? take - i : OB;
      w.data = '0;
      for (int j = 0; j < cnt; j++) w.data[8*j +: 8] = fr[HDR + 4 + i + j];
      w.keep = 4'((1 << cnt) - 1);
      w.last = (i + OB >= take);
      exp_words.push_back(w);
    end
    if (avail >= int'(size)) exp_ok++;
    else begin exp_dropped++; exp_ferr++; end
  endtask

  task automatic send_frame(input bq_t fr, input bit en, output int stalls);
    stalls = 0;
    @(posedge axi_tclk); #1;
    enable_rx_decode = en;
    foreach (fr[i]) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        axis.rx_axis_tvalid = 1'b0;
        @(posedge axi_tclk); #1;
      end
      axis.rx_axis_tvalid = 1'b1;
      axis.rx_axis_tdata  = fr[i];
      axis.rx_axis_tlast  = (i == fr.size() - 1);
      forever begin
        @(negedge axi_tclk);
        if (axis.rx_axis_tready) break;
        stalls++;
        if (stalls > 20000) begin
          $display("FAIL send_timeout: got tready stuck low expected a transfer");
          $fatal(1);
        end
      end
      @(posedge axi_tclk); #1;
    end
    axis.rx_axis_tvalid = 1'b0;
    axis.rx_axis_tlast  = 1'b0;
  endtask

  task automatic run_frame(input bq_t fr, input bit en, output int stalls);
    model_frame(fr, en);
    send_frame(fr, en, stalls);
  endtask

  task automatic settle(input string tag);
    int n = 0;
    while ((exp_words.size() != 0 || exp_meta.size() != 0) && n < 1000) begin
      @(negedge axi_tclk);
      n++;
    end
    repeat (4) @(negedge axi_tclk);
    check({tag, "_words_left"}, exp_words.size(), 0);
    check({tag, "_meta_left"}, exp_meta.size(), 0);
    check({tag, "_stat_ok"}, stat_frames_ok, exp_ok);
    check({tag, "_stat_dropped"}, stat_frames_dropped, exp_dropped);
    check({tag, "_frame_err_cnt"}, seen_ferr, exp_ferr);
  endtask

  // Output side: random backpressure, forced low while stall is set.
  initial begin
    axis.m_axis_tready = 1'b0;
    forever begin
      @(posedge axi_tclk); #1;
      axis.m_axis_tready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every output event against the scoreboard queues.
  always @(negedge axi_tclk) begin
    word_t w;
    meta_t m;
    if (!axi_treset) begin
      if (axis.m_axis_tvalid && axis.m_axis_tready) begin
        if (exp_words.size() == 0) check("unexpected_word", axis.m_axis_tdata, 64'hdead);
        else begin
          w = exp_words.pop_front();
          check("word_data", axis.m_axis_tdata, w.data);
          check("word_keep", axis.m_axis_tkeep, w.keep);
          check("word_last", axis.m_axis_tlast, w.last);
        end
      end
      if (meta_valid) begin
        if (exp_meta.size() == 0) check("unexpected_meta", meta_pkt_counter, 64'hdead);
        else begin
          m = exp_meta.pop_front();
          check("meta_size", meta_pkt_size, m.size);
          check("meta_counter", meta_pkt_counter, m.ctr);
          check("meta_src", meta_src_mac, m.src);
          check("seq_err", seq_err, m.seq);
        end
      end else if (seq_err) check("seq_err_stray", seq_err, 0);
      if (frame_err) seen_ferr++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    bq_t         fr;
    int          st;
    logic [15:0] ctr;
    logic [15:0] sz;
    int          kind;
    axis.rx_axis_tvalid = 1'b0;
    axis.rx_axis_tdata  = '0;
    axis.rx_axis_tlast  = 1'b0;

    repeat (3) @(posedge axi_tclk);
    @(negedge axi_tclk);
    check("rst_rx_tready", axis.rx_axis_tready, 0);
    check("rst_m_tvalid", axis.m_axis_tvalid, 0);
    check("rst_m_tdata", axis.m_axis_tdata, 0);
    check("rst_m_tkeep", axis.m_axis_tkeep, 0);
    check("rst_m_tlast", axis.m_axis_tlast, 0);
    check("rst_meta_valid", meta_valid, 0);
    check("rst_meta_size", meta_pkt_size, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_stat_ok", stat_frames_ok, 0);
    check("rst_stat_dropped", stat_frames_dropped, 0);
    @(posedge axi_tclk); #1;
    axi_treset = 1'b0;
    repeat (3) @(posedge axi_tclk);

    fr = make_frame(DEST, 48'h112233445566, 16'd6, 16'h0010, 6, 0, 1'b1, 0);
    run_frame(fr, 1'b1, st); settle("basic");
    fr = make_frame(DEST, 48'h0a0b0c0d0e0f, 16'd8, 16'h0012, 8, 4, 1'b0, 0);
    run_frame(fr, 1'b1, st); settle("seq_gap_pad");
    fr = make_frame(DEST, 48'h0a0b0c0d0e0f, 16'd3, 16'hffff, 3, 0, 1'b0, 0);
    run_frame(fr, 1'b1, st); settle("ctr_ffff");
    fr = make_frame(DEST, 48'h0a0b0c0d0e0f, 16'd5, 16'h0000, 5, 0, 1'b0, 0);
    run_frame(fr, 1'b1, st); settle("ctr_wrap");
    fr = make_frame(DEST, 48'h0a0b0c0d0e0f, 16'd10, 16'h0001, 7, 0, 1'b1, 0);
    run_frame(fr, 1'b1, st); settle("short_payload");
    fr = make_frame(DEST, 48'h0a0b0c0d0e0f, 16'd2000, 16'h0002, 20, 0, 1'b0, 0);
    run_frame(fr, 1'b1, st); settle("too_big");
    check("too_big_tready_held", st, 0);
    fr = make_frame(DEST, 48'h0a0b0c0d0e0f, 16'd4, 16'h0003, 4, 0, 1'b0, 0);
    run_frame(fr, 1'b0, st); settle("disabled");
    fr = make_frame(DEST, 48'h0a0b0c0d0e0f, 16'd4, 16'h0004, 4, 0, 1'b0, 9);
    run_frame(fr, 1'b1, st); settle("hdr_runt");
    fr = make_frame(DEST, 48'h0a0b0c0d0e0f, 16'd0, 16'h0005, 0, 3, 1'b0, 0);
    run_frame(fr, 1'b1, st); settle("size_zero");
    fr = make_frame(48'h5a0102030405, 48'h0a0b0c0d0e0f, 16'd4, 16'h0006, 4, 0, 1'b0, 0);
    run_frame(fr, 1'b1, st); settle("dst_other");
    fr = make_frame(48'hffffffffffff, 48'h0a0b0c0d0e0f, 16'd4, 16'h0007, 4, 0, 1'b0, 0);
    run_frame(fr, 1'b1, st); settle("dst_bcast");

    fr = make_frame(DEST, 48'h0a0b0c0d0e0f, 16'd40, 16'h0008, 40, 0, 1'b0, 0);
    fork
      run_frame(fr, 1'b1, st);
      begin
        repeat (30) @(posedge axi_tclk);
        #1 stall = 1'b1;
        repeat (20) @(posedge axi_tclk);
        @(negedge axi_tclk);
        check("stall_m_tvalid", axis.m_axis_tvalid, 1);
        check("stall_rx_tready", axis.rx_axis_tready, 0);
        @(posedge axi_tclk); #1 stall = 1'b0;
      end
    join
    settle("stall");

    ctr = 16'h0100;
    for (int f = 0; f < 30; f++) begin
      gap_pct = $urandom_range(0, 30);
      ctr = ($urandom_range(0, 4) == 0) ? 16'($urandom) : ctr + 16'd1;
      kind = $urandom_range(0, 9);
      sz = 16'($urandom_range(0, 40));
      case (kind)
        0: fr = make_frame(DEST, 48'($urandom), sz, ctr, 0, 0, 1'b0, $urandom_range(1, 18));
        1: fr = make_frame(DEST, 48'($urandom), 16'($urandom_range(1501, 4000)), ctr, 6, 0, 1'b0, 0);
        2: fr = make_frame(DEST, 48'($urandom), sz + 16'd1, ctr, $urandom_range(1, int'(sz) + 1) - 1 + 1 - 1 + 0 == 0 ? 1 : int'(sz), 0, 1'b0, 0);
        default: fr = make_frame(DEST, 48'($urandom), sz, ctr, int'(sz), $urandom_range(0, 3), 1'b0, 0);
      endcase
      run_frame(fr, $urandom_range(0, 7) != 0, st);
    end
    settle("random");

    gap_pct = 0;
    fr = make_frame(DEST, 48'h0a0b0c0d0e0f, 16'd30, 16'h0200, 30, 0, 1'b0, 0);
    fork
      send_frame(fr, 1'b1, st);
      begin
        repeat (10) @(posedge axi_tclk);
        #1 axi_treset = 1'b1;
        exp_ok = 0; exp_dropped = 0; exp_ferr = 0; seen_ferr = 0; ref_valid = 1'b0;
        @(negedge axi_tclk);
        check("midrst_rx_tready", axis.rx_axis_tready, 0);
        check("midrst_m_tvalid", axis.m_axis_tvalid, 0);
        check("midrst_stat_ok", stat_frames_ok, 0);
        check("midrst_stat_dropped", stat_frames_dropped, 0);
        @(posedge axi_tclk); #1 axi_treset = 1'b0;
      end
    join
    settle("mid_reset");
    fr = make_frame(DEST, 48'h0a0b0c0d0e0f, 16'd9, 16'h0777, 9, 1, 1'b0, 0);
    run_frame(fr, 1'b1, st); settle("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kc705_ethernet_axi_rx_frame_parser.md
Name: kc705_ethernet_axi_rx_frame_parser

Overview:
Parametrised successor to the single-byte RX decoder. Parses Ethernet command frames from the TEMAC 8-bit RX AXI-Stream: MAC header, optional VLAN tag, size field, packet counter, then payload. Packs the payload into an OUT_BYTES-wide AXI-Stream with tkeep. Also provides per-frame metadata, sequence-gap detection, length-error detection and status counters. Sits between the TEMAC RX client interface and the command/register-map FIFO.

Parameters:
DEST_ADDR, 48'hda0102030405, local MAC address used by the address filter
MAX_SIZE, 16'd1500, largest accepted size-field value in bytes; larger frames are dropped
ENABLE_VLAN, 1'b0, 1 = header carries a 4-byte 802.1Q tag (header is 18 bytes instead of 14)
PKT_SIZE_LEN, 2, size-field length in bytes, MSB first
PKT_CTR_LEN, 2, counter-field length in bytes, MSB first
OUT_BYTES, 4, output word width in bytes (1..8)

Ports:
axi_tclk  in  1  clock
axi_treset  in  1  asynchronous reset, active-high
enable_rx_decode  in  1  parse enable
rx_axis_tdata  in  8  input byte
rx_axis_tvalid  in  1  input valid
rx_axis_tlast  in  1  last byte of the MAC frame
rx_axis_tready  out  1  input ready
m_axis_tdata  out  8*OUT_BYTES  packed payload; first byte in [7:0]
m_axis_tkeep  out  OUT_BYTES  byte enables, contiguous from bit 0
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  last payload word
m_axis_tready  in  1  output ready
meta_valid  out  1  one-cycle pulse when the counter field completes
meta_pkt_size  out  8*PKT_SIZE_LEN  parsed size field
meta_pkt_counter  out  8*PKT_CTR_LEN  parsed counter field
meta_src_mac  out  48  parsed source MAC
seq_err  out  1  pulse: counter field != previous counter + 1
frame_err  out  1  pulse: tlast arrived before pkt_size payload bytes
stat_frames_ok  out  32  count of completed frames, wraps
stat_frames_dropped  out  32  count of dropped frames, wraps

Behaviour:
- Reset: all outputs 0, rx_axis_tready 0, state SYNC, sequence reference invalid.
- A byte transfers when rx_axis_tvalid & rx_axis_tready; all counters advance only on a transfer.
- SYNC: rx_axis_tready=1; discard bytes. Go to IDLE on a transferred tlast or any cycle with rx_axis_tvalid=0. This keeps a reset mid-frame from parsing a partial frame.
- IDLE: rx_axis_tready=1.
  - First byte with enable_rx_decode=1: byte 0 of HEADER; state HEADER.
  - First byte with enable_rx_decode=0: state DRAIN; the frame is not counted.
- HEADER: HDR_LEN = 14 or 18 bytes. Bytes 0-5 are destination MAC; bytes 6-11 are source MAC. After the last header byte go to SIZE.
- SIZE: PKT_SIZE_LEN bytes, MSB first. After the last byte go to COUNTER.
- COUNTER: PKT_CTR_LEN bytes. On the last byte:
  - meta_valid pulses the next cycle with all meta_* fields stable.
  - If pkt_size > MAX_SIZE: dropped+1, state DRAIN.
  - If pkt_size == 0: output nothing, ok+1, state DRAIN.
  - Otherwise: state DATA.
  - seq_err pulses with meta_valid if the reference is valid and counter != ref+1 (mod 2^(8*PKT_CTR_LEN)). The reference then updates and becomes valid.
- tlast during HEADER/SIZE/COUNTER: runt; dropped+1, frame_err pulse, state IDLE, no meta_valid.
- DATA: rx_axis_tready = !m_axis_tvalid | m_axis_tready.
  - Bytes pack into lanes 0..OUT_BYTES-1.
  - A word is emitted when all lanes are full, when the pkt_size-th byte arrives, or on input tlast.
  - m_axis_tvalid rises the cycle after the completing byte, so latency is 1.
  - Word held stable until m_axis_tready.
- pkt_size-th byte reached: word carries m_axis_tlast; ok+1. If it is not the input tlast, go to DRAIN (padding/FCS discarded); else go to IDLE.
- Input tlast before pkt_size bytes: emit the partial word with m_axis_tlast=1; frame_err pulse; dropped+1; state IDLE.
- DRAIN: rx_axis_tready=1; discard until tlast, then IDLE.
- enable_rx_decode deasserted mid-frame: the current frame completes normally.

Optional Feature:
RX_ADDR_FILTER_EN
- Defined: after destination byte 5, destination must equal DEST_ADDR or 48'hffffffffffff. On mismatch: dropped+1, state DRAIN, no meta_valid, no seq_err.
- Undefined: all destinations accepted; DEST_ADDR unused.

Decomposition:
- Package kc705_eth_rx_pkg:
  - state enum (SYNC, IDLE, HEADER, SIZE, COUNTER, DATA, DRAIN)
  - HDR_LEN_NOVLAN=14, HDR_LEN_VLAN=18
  - BCAST_MAC
- Sub-module kc705_eth_rx_byte_packer (byte in, OUT_BYTES word out, tkeep/tlast, single output register) instantiated in DATA.

Test Plan:
- OUT_BYTES=4, size=6, counter=0x0010, payload 01..06 followed by tlast → words 0x04030201/keep 0xF, then 0x0000_0605/keep 0x3/tlast; meta_valid once; stat_frames_ok=1.
- Two frames with counters 0x0010 then 0x0012 → seq_err pulses on the second; counter 0xFFFF then 0x0000 → no seq_err.
- size=10, tlast after 7 payload bytes → last word keep 0x7 with tlast; frame_err pulse; dropped=1; next frame parses normally.
- size=2000 (>MAX_SIZE) → no output; dropped=1; rx_axis_tready held 1 through tlast.
- m_axis_tready low 20 cycles mid-payload → rx_axis_tready low; no byte lost or duplicated; reset asserted mid-frame → outputs 0, rest of frame discarded in SYNC.
- Filter on, destination 5a0102030405 → dropped=1, no meta_valid; destination ffffffffffff → accepted.
